// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the program-memory / X-Y-Z-ALU datapath.
// The slave side is the sequencer; the master side is whatever drives run/funcao and consumes the controls.
interface control_sequencer_if #(
  parameter int CNT_W = 8
) ();

  // Handshake: there is no backpressure. funcao must be valid on the clock edge
  // that ends the last FETCH cycle; pc_inc is a one-cycle strobe and the PC
  // advances on the edge that ends it. run is sampled only when entering FETCH.
  logic             run;
  logic [3:0]       funcao;
  logic [1:0]       tx;
  logic [1:0]       ty;
  logic [1:0]       tz;
  logic             tula;
  logic             pc_inc;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    output run,
    output funcao,
    input  tx,
    input  ty,
    input  tz,
    input  tula,
    input  pc_inc,
    input  halted,
    input  illegal,
    input  retired
  );

  modport slave (
    input  run,
    input  funcao,
    output tx,
    output ty,
    output tz,
    output tula,
    output pc_inc,
    output halted,
    output illegal,
    output retired
  );

endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: fetch a function code, drive X/Y/Z/ALU controls for one
// or two execute cycles, pulse the PC advance, and count retired instructions.
module control_sequencer #(
  parameter int FETCH_WAIT = 1,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  control_sequencer_if.slave bus,
  output logic [2:0]         state_o
);

  if (FETCH_WAIT < 1 || FETCH_WAIT > 7) begin : g_bad_fetch_wait
    $error("control_sequencer: FETCH_WAIT must be in 1..7");
  end

  localparam logic [1:0] REG_HOLD  = 2'b00;
  localparam logic [1:0] REG_LOAD  = 2'b01;
  localparam logic [1:0] REG_CLR   = 2'b10;
  localparam logic [1:0] REG_SHR   = 2'b11;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_LDX    = 4'b0001;
  localparam logic [3:0] OP_CLR    = 4'b0010;
  localparam logic [3:0] OP_ADD    = 4'b0011;
  localparam logic [3:0] OP_SUB    = 4'b0100;
  localparam logic [3:0] OP_MOVZ   = 4'b0101;
  localparam logic [3:0] OP_SHRY   = 4'b0110;
  localparam logic [3:0] OP_ADDMOV = 4'b0111;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  localparam logic [2:0] WAIT_LAST = 3'(FETCH_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_ADV   = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  typedef struct packed {
    logic [1:0] tx;
    logic [1:0] ty;
    logic [1:0] tz;
    logic       tula;
    logic       illegal;
  } ctrl_t;

  // First-execute-cycle controls for a function code; 1000..1110 decode as NOP + illegal.
  function automatic ctrl_t decode(input logic [3:0] code);
    ctrl_t c;
    c = '0;
    case (code)
      OP_NOP, OP_HALT: ;
      OP_LDX:          c.tx = REG_LOAD;
      OP_CLR: begin
        c.tx = REG_CLR;
        c.ty = REG_CLR;
        c.tz = REG_CLR;
      end
      OP_ADD:          c.ty = REG_LOAD;
      OP_SUB: begin
        c.ty   = REG_LOAD;
        c.tula = 1'b1;
      end
      OP_MOVZ:         c.tz = REG_LOAD;
      OP_SHRY:         c.ty = REG_SHR;
      OP_ADDMOV:       c.ty = REG_LOAD;
      default:         c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  state_t           state_q;
  logic [3:0]       ir_q;
  logic [2:0]       wait_q;
  logic [CNT_W-1:0] retired_q;
  logic [1:0]       tx_q;
  logic [1:0]       ty_q;
  logic [1:0]       tz_q;
  logic             tula_q;
  logic             pc_inc_q;
  logic             halted_q;
  logic             illegal_q;

  ctrl_t            fetch_dec_d;
  logic [CNT_W-1:0] retired_d;

  always_comb begin
    fetch_dec_d = decode(bus.funcao);
    retired_d   = retired_q + CNT_W'(1);
  end

  // Controls are registered on the transition into the cycle that uses them, so
  // funcao only reaches an output through the flop that also latches ir.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      tx_q      <= REG_HOLD;
      ty_q      <= REG_HOLD;
      tz_q      <= REG_HOLD;
      tula_q    <= 1'b0;
      pc_inc_q  <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      tx_q      <= REG_HOLD;
      ty_q      <= REG_HOLD;
      tz_q      <= REG_HOLD;
      tula_q    <= 1'b0;
      pc_inc_q  <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.run) begin
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (wait_q == WAIT_LAST) begin
            wait_q    <= '0;
            ir_q      <= bus.funcao;
            state_q   <= S_EXEC1;
            tx_q      <= fetch_dec_d.tx;
            ty_q      <= fetch_dec_d.ty;
            tz_q      <= fetch_dec_d.tz;
            tula_q    <= fetch_dec_d.tula;
            illegal_q <= fetch_dec_d.illegal;
          end else begin
            wait_q <= wait_q + 3'd1;
          end
        end
        S_EXEC1: begin
          if (ir_q == OP_HALT) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else if (ir_q == OP_ADDMOV) begin
            state_q <= S_EXEC2;
            tz_q    <= REG_LOAD;
          end else begin
            state_q   <= S_ADV;
            pc_inc_q  <= 1'b1;
            retired_q <= retired_d;
          end
        end
        S_EXEC2: begin
          state_q   <= S_ADV;
          pc_inc_q  <= 1'b1;
          retired_q <= retired_d;
        end
        // run is only honoured here, so a drop mid-instruction lets it finish.
        S_ADV: begin
          state_q <= bus.run ? S_FETCH : S_IDLE;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx      = tx_q;
  assign bus.ty      = ty_q;
  assign bus.tz      = tz_q;
  assign bus.tula    = tula_q;
  assign bus.pc_inc  = pc_inc_q;
  assign bus.halted  = halted_q;
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;
  assign state_o     = state_q;

endmodule
